// File: rtl/muldiv_if.sv
// Request/result bundle between an issuing core and the iterative
// multiply/divide unit. The master drives the request and the slave returns
// the register-file write-back.
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  dst;
  logic        busy;
  logic [31:0] wd;
  logic [4:0]  wn;
  logic        write;

  modport master (output start, op, A, B, dst, input busy, wd, wn, write);
  modport slave  (input start, op, A, B, dst, output busy, wd, wn, write);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned multiply/divide unit with a fixed latency.
// One shift-add (multiply) or restoring-subtract (divide) step per RUN cycle,
// 32 steps, one extra cycle to present the result, then a DONE write-back
// cycle. The 64-bit working pair {hi_q, lo_q} serves both operations:
//   multiply: hi_q = partial product high half, lo_q = multiplier/product low
//   divide:   hi_q = partial remainder,         lo_q = dividend/quotient
module muldiv_unit (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic        fin_q;
  logic [1:0]  op_q;
  logic [4:0]  dst_q;
  logic [31:0] m_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_n, lo_n;

  logic        busy_q;
  logic        write_q;
  logic [31:0] wd_q;
  logic [4:0]  wn_q;

  logic [32:0] mul_sum;
  logic        div_ge;
  logic [31:0] div_rem;

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (fin_q)     state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // One iteration of the selected algorithm from the current working pair.
  always_comb begin
    mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : 32'd0)};
    // Shifted partial remainder is {hi_q, lo_q[31]}; its top bit alone
    // guarantees it is at least the divisor. A zero divisor always
    // subtracts, yielding an all-ones quotient and the dividend as remainder.
    div_ge  = hi_q[31] || ({hi_q[30:0], lo_q[31]} >= m_q);
    div_rem = {hi_q[30:0], lo_q[31]} - m_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    if (!op_q[1]) begin
      hi_n = mul_sum[32:1];
      lo_n = {mul_sum[0], lo_q[31:1]};
    end else if (div_ge) begin
      hi_n = div_rem;
      lo_n = {lo_q[30:0], 1'b1};
    end else begin
      hi_n = {hi_q[30:0], lo_q[31]};
      lo_n = {lo_q[30:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every datapath register is reset, so an aborted operation leaves
    // no stale operands behind for the next one.
    if (!reset) begin
      cnt_q <= 5'd0;
      fin_q <= 1'b0;
      op_q  <= 2'd0;
      dst_q <= 5'd0;
      m_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values.
      unique case (state_q)
        IDLE: if (bus.start) begin
          cnt_q <= 5'd0;
          fin_q <= 1'b0;
          op_q  <= bus.op;
          dst_q <= bus.dst;
          hi_q  <= 32'd0;
          m_q   <= bus.op[1] ? bus.B : bus.A;
          lo_q  <= bus.op[1] ? bus.A : bus.B;
        end
        RUN: if (!fin_q) begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) fin_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs: result capture, write pulse and busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q  <= 1'b0;
      write_q <= 1'b0;
      wd_q    <= 32'd0;
      wn_q    <= 5'd0;
    end else begin
      busy_q  <= (state_d != IDLE);
      write_q <= 1'b0;
      if (state_q == RUN && fin_q) begin
        // Odd opcodes (MULHU, REMU) take the high/remainder half.
        wd_q    <= op_q[0] ? hi_q : lo_q;
        wn_q    <= dst_q;
        write_q <= (dst_q != 5'd0);
      end
    end
  end

  assign bus.busy  = busy_q;
  assign bus.write = write_q;
  assign bus.wd    = wd_q;
  assign bus.wn    = wn_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, random operations
// against an arithmetic reference model, and reset aborts in RUN and DONE.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  muldiv_if bus ();

  muldiv_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, divide-by-zero rules applied directly.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one operation and watch 34 edges after acceptance.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] dst, input bit disturb);
    int          wr_cnt, wr_edge, busy_fall;
    logic [31:0] exp;
    exp = model(op, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b; bus.dst = dst;
    @(posedge clk);
    #1;
    check({tag, " busy_at_accept"}, 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    bus.A = $urandom; bus.B = $urandom; bus.op = 2'($urandom); bus.dst = 5'($urandom);
    wr_cnt = 0; wr_edge = -1; busy_fall = -1;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      #1;
      if (bus.write) begin
        wr_cnt++;
        if (wr_edge < 0) wr_edge = k;
      end
      if (!bus.busy && busy_fall < 0) busy_fall = k;
      if (disturb && k == 4) begin
        bus.start = 1'b1; bus.A = 32'd9; bus.B = 32'd9; bus.op = 2'd1; bus.dst = 5'd9;
      end
      if (k == 5) bus.start = 1'b0;
    end
    check({tag, " write_count"}, 32'(wr_cnt), (dst != 0) ? 32'd1 : 32'd0);
    check({tag, " write_edge"}, 32'(wr_edge), (dst != 0) ? 32'd33 : 32'hFFFF_FFFF);
    check({tag, " busy_fall_edge"}, 32'(busy_fall), 32'd34);
    check({tag, " wd"}, bus.wd, exp);
    check({tag, " wn"}, 32'(bus.wn), 32'(dst));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},  32'(bus.busy),  32'd0);
    check({tag, " write"}, 32'(bus.write), 32'd0);
    check({tag, " wd"},    bus.wd,         32'd0);
    check({tag, " wn"},    32'(bus.wn),    32'd0);
  endtask

  initial begin
    int wr_cnt;
    bus.start = 1'b0; bus.op = 2'd0; bus.A = 32'd0; bus.B = 32'd0; bus.dst = 5'd0;
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_initial");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed cases.
    run_op("mulu_basic", 2'd0, 32'h0000_1234, 32'h0000_0010, 5'd5, 1'b0);
    run_op("mulhu_max",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0);
    run_op("mulu_max",   2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0);
    run_op("divu_100_7", 2'd2, 32'd100, 32'd7, 5'd3, 1'b0);
    run_op("remu_100_7", 2'd3, 32'd100, 32'd7, 5'd4, 1'b0);
    run_op("divu_by0",   2'd2, 32'h55, 32'd0, 5'd8, 1'b0);
    run_op("remu_by0",   2'd3, 32'h55, 32'd0, 5'd9, 1'b0);
    run_op("mulu_dst0",  2'd0, 32'd6, 32'd7, 5'd0, 1'b0);

    // Result registers hold between operations.
    repeat (5) @(posedge clk);
    #1;
    check("hold wd", bus.wd, 32'd42);
    check("hold wn", 32'(bus.wn), 32'd0);

    // Start during RUN with new operands must be ignored.
    run_op("mulu_3x4_disturbed", 2'd0, 32'd3, 32'd4, 5'd2, 1'b1);

    // Second run aborted by reset in RUN at E0+10.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.A = 32'd11; bus.B = 32'd13; bus.dst = 5'd6;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_in_run");
    wr_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.write || bus.busy) wr_cnt++;
    end
    check("reset_in_run no_activity", 32'(wr_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // First operation after reset behaves normally.
    run_op("after_reset_divu", 2'd2, 32'd1000, 32'd33, 5'd12, 1'b0);

    // Reset during the DONE cycle kills the write pulse at once.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd3; bus.A = 32'd77; bus.B = 32'd10; bus.dst = 5'd15;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    check("done write_before_reset", 32'(bus.write), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_in_done");
    @(negedge clk);
    reset = 1'b1;

    // Random operations, back-to-back, against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      run_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), ra, rb,
             ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
